// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types for the dual-requester issue controller.
// Instruction layout, opcodes and controller states.
package pipe_pkg;

  localparam int INSTR_W  = 24;
  localparam int FUNC_LSB = 20;
  localparam int RD_LSB   = 16;
  localparam int RS1_LSB  = 12;
  localparam int RS2_LSB  = 8;
  localparam int ADDR_LSB = 0;

  typedef struct packed {
    logic [3:0] func;
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic [7:0] addr;
  } instr_t;

  localparam logic [3:0] ADD      = 4'd0;
  localparam logic [3:0] SUB      = 4'd1;
  localparam logic [3:0] AND      = 4'd2;
  localparam logic [3:0] OR       = 4'd3;
  localparam logic [3:0] XOR      = 4'd4;
  localparam logic [3:0] SLT      = 4'd5;
  localparam logic [3:0] SLTU     = 4'd6;
  localparam logic [3:0] LD       = 4'd7;
  localparam logic [3:0] ST       = 4'd8;
  localparam logic [3:0] BEQ      = 4'd9;
  localparam logic [3:0] BNE      = 4'd10;
  localparam logic [3:0] SHL      = 4'd11;
  localparam logic [3:0] FUNC_MAX = SHL;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

  function automatic instr_t get_instr(
    input logic [INSTR_W-1:0] w
  );
    instr_t r;
    r.func = w[FUNC_LSB +: 4];
    r.rd   = w[RD_LSB   +: 4];
    r.rs1  = w[RS1_LSB  +: 4];
    r.rs2  = w[RS2_LSB  +: 4];
    r.addr = w[ADDR_LSB +: 8];
    return r;
  endfunction

endpackage

// File: rtl/pipe_issue_ctrl_if.sv
// pipe_issue_ctrl_if: request side and issue side of the controller.
// master = instruction source / datapath, slave = controller.
interface pipe_issue_ctrl_if #(
  parameter int CNT_W = 8
);
  logic [1:0]       req_valid;
  logic [23:0]      req0_instr;
  logic [23:0]      req1_instr;
  logic [1:0]       req_ready;
  logic             flush;
  logic             iss_valid;
  logic [3:0]       iss_func;
  logic [3:0]       iss_rd;
  logic [3:0]       iss_rs1;
  logic [3:0]       iss_rs2;
  logic [7:0]       iss_addr;
  logic             iss_src;
  logic             illegal;
  logic             busy;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output req_valid, req0_instr, req1_instr, flush,
    input  req_ready, iss_valid, iss_func, iss_rd,
    input  iss_rs1, iss_rs2, iss_addr, iss_src,
    input  illegal, busy, stall_cnt
  );

  modport slave (
    input  req_valid, req0_instr, req1_instr, flush,
    output req_ready, iss_valid, iss_func, iss_rd,
    output iss_rs1, iss_rs2, iss_addr, iss_src,
    output illegal, busy, stall_cnt
  );

endinterface

// File: rtl/pipe_issue_ctrl_scoreboard.sv
// pipe_scoreboard: per-register pending bits retired by a
// WB_LAT-deep line of {valid, rd} behind each issued write.
module pipe_scoreboard #(
  parameter int WB_LAT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        set_en,
  input  logic [3:0]  set_rd,
  output logic [15:0] pending,
  output logic        empty
);

  logic [WB_LAT-1:0]      sh_v;
  logic [WB_LAT-1:0][3:0] sh_rd;
  logic [15:0]            pend_q;
  logic [15:0]            set_m;
  logic [15:0]            clr_m;
  logic [15:0]            young_m;

  // Set/clear masks; a retiring write keeps its bit if a younger
  // write to the same register is still in the line.
  always_comb begin
    set_m   = '0;
    clr_m   = '0;
    young_m = '0;
    if (set_en) set_m[set_rd] = 1'b1;
    for (int i = 0; i < WB_LAT - 1; i++) begin
      if (sh_v[i]) young_m[sh_rd[i]] = 1'b1;
    end
    if (sh_v[WB_LAT-1]) clr_m[sh_rd[WB_LAT-1]] = 1'b1;
    clr_m = clr_m & ~young_m;
  end

  // Shift line and pending vector; set wins over clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_v   <= '0;
      sh_rd  <= '0;
      pend_q <= '0;
    end else begin
      sh_v[0]  <= set_en;
      sh_rd[0] <= set_rd;
      for (int i = 1; i < WB_LAT; i++) begin
        sh_v[i]  <= sh_v[i-1];
        sh_rd[i] <= sh_rd[i-1];
      end
      pend_q <= (pend_q & ~clr_m) | set_m;
    end
  end

  assign pending = pend_q;
  assign empty   = (pend_q == '0) && (sh_v == '0);

endmodule

// File: rtl/pipe_issue_ctrl.sv
// pipe_issue_ctrl: round-robin issue of two requesters with RAW
// hazard scoreboard and flush drain. Option: PIPE_STALL_CNT_EN.
module pipe_issue_ctrl
  import pipe_pkg::*;
#(
  parameter int WB_LAT = 3,
  parameter int CNT_W  = 8
) (
  input logic              clk,
  input logic              rst_n,
  pipe_issue_ctrl_if.slave bus
);

  instr_t      ins [2];
  instr_t      gins;
  instr_t      iss_q;
  state_t      state;
  state_t      state_n;
  logic        prio;
  logic        gsel;
  logic        xfer;
  logic        legal;
  logic [1:0]  elig;
  logic [1:0]  grant;
  logic [15:0] pending;
  logic        sb_empty;
  logic        iss_v_q;
  logic        ill_q;
  logic        src_q;

  assign ins[0] = get_instr(bus.req0_instr);
  assign ins[1] = get_instr(bus.req1_instr);

  // Eligibility: valid, running, and both sources free.
  always_comb begin
    elig = '0;
    for (int i = 0; i < 2; i++) begin
      elig[i] = bus.req_valid[i] && (state == RUN)
              && !pending[ins[i].rs1]
              && !pending[ins[i].rs2];
    end
  end

  // Round-robin grant; priority side first, else the other.
  always_comb begin
    grant = '0;
    unique case (prio)
      1'b0: grant = elig[0] ? 2'b01 : {elig[1], 1'b0};
      1'b1: grant = elig[1] ? 2'b10 : {1'b0, elig[0]};
    endcase
  end

  assign bus.req_ready = grant;
  assign xfer  = |grant;
  assign gsel  = grant[1];
  assign gins  = gsel ? ins[1] : ins[0];
  assign legal = (gins.func <= FUNC_MAX);

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_n;
  end

  // Next state: flush enters drain, empty scoreboard leaves it.
  always_comb begin
    state_n = state;
    unique case (state)
      RUN:   if (bus.flush) state_n = DRAIN;
      DRAIN: if (sb_empty)  state_n = RUN;
    endcase
  end

  // Issue register, illegal pulse and priority pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_v_q <= 1'b0;
      ill_q   <= 1'b0;
      src_q   <= 1'b0;
      iss_q   <= '0;
      prio    <= 1'b0;
    end else begin
      iss_v_q <= xfer && legal;
      ill_q   <= xfer && !legal;
      if (xfer) prio <= ~gsel;
      if (xfer && legal) begin
        iss_q <= gins;
        src_q <= gsel;
      end
    end
  end

  pipe_scoreboard #(
    .WB_LAT (WB_LAT)
  ) u_sb (
    .clk     (clk),
    .rst_n   (rst_n),
    .set_en  (xfer && legal),
    .set_rd  (gins.rd),
    .pending (pending),
    .empty   (sb_empty)
  );

  assign bus.iss_valid = iss_v_q;
  assign bus.iss_func  = iss_q.func;
  assign bus.iss_rd    = iss_q.rd;
  assign bus.iss_rs1   = iss_q.rs1;
  assign bus.iss_rs2   = iss_q.rs2;
  assign bus.iss_addr  = iss_q.addr;
  assign bus.iss_src   = src_q;
  assign bus.illegal   = ill_q;
  assign bus.busy      = (pending != '0) || (state == DRAIN);

`ifdef PIPE_STALL_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Count cycles with a request but no transfer, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if ((|bus.req_valid) && !xfer && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.stall_cnt = cnt_q;
`else
  assign bus.stall_cnt = {CNT_W{1'b0}};
`endif

endmodule
